dragon_collision_scanner: RTL
=============================

// Module: dragon_collision_scanner
// PURPOSE
//  Reads the dragon head and seven body segment registers once per frame.
//  Compares each live segment against the player and sword tile positions.
//  Produces the single-cycle hit pulse that drives the dragon body's shrink
//  input, a player_hurt pulse for the player logic, and a live-segment count.
//  Sits between the dragon body queue and the player/sword logic.
// PARAMETERS
//  NUM_SEG    7      body segments after the head (fixed to match the body queue)
//  POS_W      8      position field width; segment word is {orient[1:0], pos[POS_W-1:0]}
//  EMPTY_POS  8'hFB  sentinel position of an unused segment; never matches
// PORTS
//  clk           in   1   clock
//  reset         in   1   reset, synchronous, active-low
//  vsync         in   1   frame sync; the scan starts on its rising edge
//  dragon_head   in   10  [9:8] orientation, [7:0] position; always treated as enabled
//  dragon_1..7   in   10  body segments, same encoding as dragon_head
//  display_en    in   7   bit i-1 enables dragon_i
//  player_pos    in   8   player tile position
//  sword_pos     in   8   sword tile position
//  sword_active  in   1   sword is currently out
//  dragon_hit    out  1   1-clk pulse; the sword struck a live segment this frame
//  player_hurt   out  1   1-clk pulse; the player overlaps a live segment this frame
//  hit_index     out  3   lowest segment index struck by the sword (0 = head)
//  alive_count   out  4   1 + popcount(display_en snapshot)
//  scan_busy     out  1   high while the snapshot is being scanned
// BEHAVIOUR
//  Reset (reset==0, sampled on the clk edge):
//   - All outputs go to 0. State goes to IDLE.
//   - pre_vsync goes to 0. The snapshot registers and the match flags are cleared.
//   - Reset is honoured in every state; a scan in progress is abandoned and no pulse is emitted.
//  Edge detect: pre_vsync <= vsync every clock. A rising edge is vsync & ~pre_vsync.
//  State machine: IDLE -> SCAN -> REPORT -> IDLE.
//   IDLE:
//    - On a rising edge (clock edge E), snapshot head, dragon_1..7, display_en,
//      player_pos, sword_pos and sword_active.
//    - Clear the match flags, set idx=0, go to SCAN.
//   SCAN (idx 0..7, one segment per clock, edges E+1..E+8):
//    - live = (idx==0 | en_snap[idx-1]) & (pos != EMPTY_POS).
//    - sword_match = live & sword_active_snap & (pos == sword_pos_snap).
//      On the first sword_match, latch hit_idx_r = idx; later matches do not overwrite it.
//    - player_match = live & (pos == player_pos_snap); OR it into hurt_flag.
//    - At idx==7, go to REPORT.
//   REPORT (edge E+9):
//    - dragon_hit <= hit_flag; player_hurt <= hurt_flag.
//    - hit_index <= hit_idx_r, updated only if hit_flag; otherwise it holds its value.
//    - alive_count <= 1 + popcount(en_snap). Go to IDLE.
//   IDLE, every clock: dragon_hit and player_hurt are forced to 0, so each pulse lasts exactly one clk.
//  Latency: pulses are high during the cycle after edge E+9, i.e. 9 clocks after the edge is seen.
//  scan_busy is 1 in SCAN and REPORT and 0 in IDLE.
//  Rules:
//   - A vsync rising edge outside IDLE is ignored; no queuing.
//   - Inputs changing mid-scan have no effect; only the snapshot is used.
//   - At most one dragon_hit and one player_hurt per frame, however many segments match.
//   - The sword and the player matching in the same frame raise both pulses in the same cycle.
//   - A segment at EMPTY_POS never matches, even when it is enabled.
//   - A disabled segment never matches, even at a valid position.
//   - alive_count range is 1..8, computed in 4 bits, no overflow.
// STRUCTURE
//  Shared package: EMPTY_POS, the SEG_W=10 / POS_W=8 field slices, and the scan state enum {IDLE,SCAN,REPORT}.
//  Sub-module: seg_select, a combinational 8:1 mux that returns {live, pos} for idx from the snapshot.
//   Everything else sits in this module.
// TESTING
//  1. Hold reset=0 for 3 clks with vsync toggling -> all outputs 0, scan_busy 0, no pulses.
//  2. Head=8'h35, dragon_1=8'h34, en=7'b0000111, sword_active=1, sword_pos=8'h34, vsync rises
//     -> dragon_hit high exactly 1 clk at edge+9, hit_index=1, alive_count=4, player_hurt=0.
//  3. dragon_5=8'h50 with en[4]=0, sword_pos=8'h50 -> no dragon_hit.
//     Set en[4]=1 next frame -> dragon_hit, hit_index=5.
//  4. Sword matches segments 2 and 6, player matches the head in the same frame
//     -> one dragon_hit and one player_hurt in the same cycle, hit_index=2.
//  5. All segments at 8'hFB, en=7'h7F, player_pos=8'hFB -> no pulses, alive_count=8.
//  6. Second vsync edge at E+4, then reset=0 at E+6 -> no pulse, IDLE.
//     The next vsync edge starts a clean scan.

Source files
------------

// File: rtl/dragon_collision_scanner_pkg.sv
// Shared field widths, sentinel position and scan state encoding for the
// dragon collision scanner.
package dragon_collision_scanner_pkg;

   localparam int NUM_SEG = 7;
   localparam int POS_W   = 8;
   localparam int SEG_W   = 10;
   localparam int IDX_W   = 3;
   localparam int CNT_W   = 4;

   localparam logic [POS_W-1:0] EMPTY_POS = 8'hFB;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      REPORT = 2'd2
   } scan_state_e;

   function automatic logic [POS_W-1:0] seg_pos(input logic [SEG_W-1:0] seg);
      return seg[POS_W-1:0];
   endfunction

   // Head is always present, so the count is one more than the enabled bodies.
   function automatic logic [CNT_W-1:0] alive_of(input logic [NUM_SEG-1:0] en);
      logic [CNT_W-1:0] cnt;
      cnt = 4'd1;
      for (int i = 0; i < NUM_SEG; i++) begin
         cnt = cnt + {3'd0, en[i]};
      end
      return cnt;
   endfunction

endpackage

// File: rtl/dragon_collision_scanner_seg_select.sv
// Combinational 8:1 segment picker: returns liveness and position of the
// snapshot entry at idx (0 = head).
module seg_select
   import dragon_collision_scanner_pkg::*;
(
   input  logic [NUM_SEG:0][POS_W-1:0] pos_i,
   input  logic [NUM_SEG-1:0]          en_i,
   input  logic [IDX_W-1:0]            idx_i,
   output logic                        live_o,
   output logic [POS_W-1:0]            pos_o
);

   logic [NUM_SEG:0] en_full;

   always_comb begin
      en_full = {en_i, 1'b1};
      pos_o   = pos_i[idx_i];
      live_o  = en_full[idx_i] & (pos_i[idx_i] != EMPTY_POS);
   end

endmodule

// File: rtl/dragon_collision_scanner.sv
// Per-frame scan of the dragon head and body against the player and sword
// tiles; emits one-clock hit/hurt pulses and the live-segment count.
module dragon_collision_scanner
   import dragon_collision_scanner_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 vsync_i,
   input  logic [SEG_W-1:0]     dragon_head_i,
   input  logic [SEG_W-1:0]     dragon_1_i,
   input  logic [SEG_W-1:0]     dragon_2_i,
   input  logic [SEG_W-1:0]     dragon_3_i,
   input  logic [SEG_W-1:0]     dragon_4_i,
   input  logic [SEG_W-1:0]     dragon_5_i,
   input  logic [SEG_W-1:0]     dragon_6_i,
   input  logic [SEG_W-1:0]     dragon_7_i,
   input  logic [NUM_SEG-1:0]   display_en_i,
   input  logic [POS_W-1:0]     player_pos_i,
   input  logic [POS_W-1:0]     sword_pos_i,
   input  logic                 sword_active_i,
   output logic                 dragon_hit_o,
   output logic                 player_hurt_o,
   output logic [IDX_W-1:0]     hit_index_o,
   output logic [CNT_W-1:0]     alive_count_o,
   output logic                 scan_busy_o
);

   scan_state_e state_q, state_d;

   logic                        pre_vsync_q;
   logic                        vsync_rise;

   logic [NUM_SEG:0][POS_W-1:0] pos_snap_q, pos_snap_d;
   logic [NUM_SEG-1:0]          en_snap_q, en_snap_d;
   logic [POS_W-1:0]            player_snap_q, player_snap_d;
   logic [POS_W-1:0]            sword_snap_q, sword_snap_d;
   logic                        sword_act_q, sword_act_d;

   logic [IDX_W-1:0]            idx_q, idx_d;
   logic                        hit_flag_q, hit_flag_d;
   logic                        hurt_flag_q, hurt_flag_d;
   logic [IDX_W-1:0]            hit_idx_q, hit_idx_d;

   logic                        dragon_hit_q, dragon_hit_d;
   logic                        player_hurt_q, player_hurt_d;
   logic [IDX_W-1:0]            hit_index_q, hit_index_d;
   logic [CNT_W-1:0]            alive_q, alive_d;

   logic                        seg_live;
   logic [POS_W-1:0]            seg_pos_w;
   logic                        sword_match;
   logic                        player_match;

   // Orientation is carried by the body queue but plays no part in collision.
   logic unused_orient;
   assign unused_orient = ^{dragon_head_i[SEG_W-1:POS_W], dragon_1_i[SEG_W-1:POS_W],
                            dragon_2_i[SEG_W-1:POS_W], dragon_3_i[SEG_W-1:POS_W],
                            dragon_4_i[SEG_W-1:POS_W], dragon_5_i[SEG_W-1:POS_W],
                            dragon_6_i[SEG_W-1:POS_W], dragon_7_i[SEG_W-1:POS_W]};

   assign vsync_rise = vsync_i & ~pre_vsync_q;

   seg_select u_seg_select (
      .pos_i  (pos_snap_q),
      .en_i   (en_snap_q),
      .idx_i  (idx_q),
      .live_o (seg_live),
      .pos_o  (seg_pos_w)
   );

   assign sword_match  = seg_live & sword_act_q & (seg_pos_w == sword_snap_q);
   assign player_match = seg_live & (seg_pos_w == player_snap_q);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= IDLE;
         pre_vsync_q   <= 1'b0;
         pos_snap_q    <= '0;
         en_snap_q     <= '0;
         player_snap_q <= '0;
         sword_snap_q  <= '0;
         sword_act_q   <= 1'b0;
         idx_q         <= '0;
         hit_flag_q    <= 1'b0;
         hurt_flag_q   <= 1'b0;
         hit_idx_q     <= '0;
         dragon_hit_q  <= 1'b0;
         player_hurt_q <= 1'b0;
         hit_index_q   <= '0;
         alive_q       <= '0;
      end else begin
         state_q       <= state_d;
         pre_vsync_q   <= vsync_i;
         pos_snap_q    <= pos_snap_d;
         en_snap_q     <= en_snap_d;
         player_snap_q <= player_snap_d;
         sword_snap_q  <= sword_snap_d;
         sword_act_q   <= sword_act_d;
         idx_q         <= idx_d;
         hit_flag_q    <= hit_flag_d;
         hurt_flag_q   <= hurt_flag_d;
         hit_idx_q     <= hit_idx_d;
         dragon_hit_q  <= dragon_hit_d;
         player_hurt_q <= player_hurt_d;
         hit_index_q   <= hit_index_d;
         alive_q       <= alive_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      pos_snap_d    = pos_snap_q;
      en_snap_d     = en_snap_q;
      player_snap_d = player_snap_q;
      sword_snap_d  = sword_snap_q;
      sword_act_d   = sword_act_q;
      idx_d         = idx_q;
      hit_flag_d    = hit_flag_q;
      hurt_flag_d   = hurt_flag_q;
      hit_idx_d     = hit_idx_q;
      dragon_hit_d  = 1'b0;
      player_hurt_d = 1'b0;
      hit_index_d   = hit_index_q;
      alive_d       = alive_q;

      case (state_q)
         IDLE: begin
            if (vsync_rise) begin
               pos_snap_d    = {seg_pos(dragon_7_i), seg_pos(dragon_6_i),
                                seg_pos(dragon_5_i), seg_pos(dragon_4_i),
                                seg_pos(dragon_3_i), seg_pos(dragon_2_i),
                                seg_pos(dragon_1_i), seg_pos(dragon_head_i)};
               en_snap_d     = display_en_i;
               player_snap_d = player_pos_i;
               sword_snap_d  = sword_pos_i;
               sword_act_d   = sword_active_i;
               idx_d         = '0;
               hit_flag_d    = 1'b0;
               hurt_flag_d   = 1'b0;
               hit_idx_d     = '0;
               state_d       = SCAN;
            end
         end

         SCAN: begin
            // First sword strike wins; later strikes only keep the flag set.
            if (sword_match && !hit_flag_q) begin
               hit_idx_d = idx_q;
            end
            hit_flag_d  = hit_flag_q | sword_match;
            hurt_flag_d = hurt_flag_q | player_match;
            idx_d       = idx_q + 3'd1;
            if (idx_q == 3'(NUM_SEG)) begin
               state_d = REPORT;
            end
         end

         REPORT: begin
            dragon_hit_d  = hit_flag_q;
            player_hurt_d = hurt_flag_q;
            if (hit_flag_q) begin
               hit_index_d = hit_idx_q;
            end
            alive_d = alive_of(en_snap_q);
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign dragon_hit_o  = dragon_hit_q;
   assign player_hurt_o = player_hurt_q;
   assign hit_index_o   = hit_index_q;
   assign alive_count_o = alive_q;
   assign scan_busy_o   = (state_q != IDLE);

endmodule
